// File: rtl/ram_memory_pkg.sv
// Purpose: shared constants and types for the ram_memory scratch store.
// Latency: n/a (declarations only).
// Backpressure: n/a; config macro RAM_MEMORY_WRITE_THROUGH_EN is consumed in ram_memory.sv.
package ram_memory_pkg;

  localparam int RAM_DATA_W = 4;
  localparam int RAM_ADDR_W = 6;
  localparam int DEPTH      = 2 ** RAM_ADDR_W;

  // ReadWrite encoding driven by the controller
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef logic [RAM_DATA_W-1:0] data_t;
  typedef logic [RAM_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ram_memory_if.sv
// Purpose: access bus between a controller (master) and the RAM (slave).
// Latency: n/a (wiring only); DataOut is registered inside the RAM.
// Backpressure: none; the RAM accepts one access every cycle.
interface ram_memory_if
  import ram_memory_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W
);

  logic              Enable;
  logic              ReadWrite;
  logic [DATA_W-1:0] DataIn;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] DataOut;

  modport master (
    output Enable, ReadWrite, DataIn, Address,
    input  DataOut
  );

  modport slave (
    input  Enable, ReadWrite, DataIn, Address,
    output DataOut
  );

endinterface

// File: rtl/ram_memory_array.sv
// Purpose: 2**ADDR_W x DATA_W storage with synchronous write and synchronous clear.
// Latency: write lands at the sampling edge; rdat is a combinational view of the addressed word.
// Backpressure: none; a write is accepted every cycle wr_en is high.
module ram_memory_array
  import ram_memory_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdat,
  output logic [DATA_W-1:0] rdat
);

  localparam int WORDS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [WORDS];

  // Clear every word on reset, otherwise commit the write; reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[addr] <= wdat;
    end
  end

  // The caller registers this value, so no input reaches its output without a flop.
  assign rdat = mem[addr];

endmodule

// File: rtl/ram_memory.sv
// Purpose: single-port synchronous RAM; decodes Enable/ReadWrite and owns the DataOut register.
// Latency: read data valid one cycle after the request edge; writes visible to the next-cycle read.
// Backpressure: none; any read/write mix every cycle. Macro RAM_MEMORY_WRITE_THROUGH_EN: writes also load DataOut.
module ram_memory
  import ram_memory_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_memory_if.slave   bus
);

  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] rd_dat;
  logic [DATA_W-1:0] dout;

  assign wr_en = bus.Enable && (bus.ReadWrite == RW_WRITE);
  assign rd_en = bus.Enable && (bus.ReadWrite == RW_READ);

  ram_memory_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .addr  (bus.Address),
    .wdat  (bus.DataIn),
    .rdat  (rd_dat)
  );

  // Output register: cleared by reset, loaded by reads, held otherwise (writes load it in write-through builds).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (rd_en) begin
      dout <= rd_dat;
`ifdef RAM_MEMORY_WRITE_THROUGH_EN
    end else if (wr_en) begin
      dout <= bus.DataIn;
`else
    end else begin
      dout <= dout;
`endif
    end
  end

  assign bus.DataOut = dout;

endmodule

// File: tb/tb_ram_memory.sv
// Purpose: directed self-checking bench for ram_memory.
// Latency: inputs change at negedge, DataOut sampled 1ns after the following posedge.
// Backpressure: n/a; honours RAM_MEMORY_WRITE_THROUGH_EN for the write-cycle expectations.
module tb_ram_memory;

`ifdef RAM_MEMORY_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  ram_memory_if #(.DATA_W(4), .ADDR_W(6)) bus ();

  ram_memory #(.DATA_W(4), .ADDR_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one access for exactly one rising edge, then settle past the edge.
  task automatic step(input logic en, input logic rw, input logic [3:0] din, input logic [5:0] addr);
    @(negedge clk);
    bus.Enable    = en;
    bus.ReadWrite = rw;
    bus.DataIn    = din;
    bus.Address   = addr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] exp);
    vecs++;
    assert (bus.DataOut === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, bus.DataOut, exp);
    end
  endtask

  initial begin
    logic [3:0] exp;
    vecs = 0;
    errs = 0;
    rst_n = 1'b0;
    bus.Enable = 1'b0;
    bus.ReadWrite = 1'b1;
    bus.DataIn = 4'h0;
    bus.Address = 6'h00;

    // Reset while a write is requested: write must be discarded
    step(1'b1, 1'b0, 4'hF, 6'h3F);
    check("reset_dout", 4'h0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 4'h0, 6'h3F);
    check("reset_write_suppressed", 4'h0);

    // Plain write then read, one-cycle latency
    step(1'b1, 1'b0, 4'h5, 6'h2A);
    step(1'b1, 1'b0, 4'hC, 6'h01);
    step(1'b1, 1'b1, 4'h0, 6'h2A);
    check("read_2a", 4'h5);
    step(1'b1, 1'b1, 4'h0, 6'h01);
    check("read_01", 4'hC);

    // Enable low: neither memory nor DataOut may change
    step(1'b1, 1'b0, 4'h9, 6'h10);
    step(1'b0, 1'b0, 4'h3, 6'h10);
    check("idle_hold", WT ? 4'h9 : 4'hC);
    step(1'b1, 1'b1, 4'h0, 6'h10);
    check("read_10_after_idle", 4'h9);

    // Back-to-back write/read of the same address, then a write observed on DataOut
    step(1'b1, 1'b0, 4'h7, 6'h00);
    step(1'b1, 1'b1, 4'h0, 6'h00);
    check("b2b_read_00", 4'h7);
    step(1'b1, 1'b0, 4'hA, 6'h00);
    check("write_dout", WT ? 4'hA : 4'h7);
    step(1'b1, 1'b1, 4'h0, 6'h00);
    check("read_00_new", 4'hA);

    // Full sweep: word = (addr ^ 5) & 0xF
    for (int a = 0; a < 64; a++) begin
      step(1'b1, 1'b0, 4'((a ^ 5) & 15), 6'(a));
    end
    for (int a = 0; a < 64; a++) begin
      step(1'b1, 1'b1, 4'h0, 6'(a));
      exp = 4'((a ^ 5) & 15);
      check($sformatf("sweep_%02h", a), exp);
    end

    // Reset in the middle of a read burst over filled memory
    step(1'b1, 1'b1, 4'h0, 6'h3F);
    check("burst_3f", 4'hA);
    step(1'b1, 1'b1, 4'h0, 6'h00);
    check("burst_00", 4'h5);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 4'h0, 6'h01);
    check("midreset_dout", 4'h0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 4'h0, 6'h01);
    check("post_reset_01", 4'h0);
    step(1'b1, 1'b1, 4'h0, 6'h2A);
    check("post_reset_2a", 4'h0);
    step(1'b1, 1'b1, 4'h0, 6'h3F);
    check("post_reset_3f", 4'h0);
    step(1'b1, 1'b1, 4'h0, 6'h00);
    check("post_reset_00", 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
